// File: rtl/audio_framer_if.sv
// Sample-stream bundle for audio_framer: the master side feeds samples in and the
// slave side (the framer) returns framed samples, their flat index and status.
interface audio_framer_if #(
    parameter int I_BW       = 14,
    parameter int TOTAL_DATA = 91136
);
    localparam int NW = $clog2(TOTAL_DATA);

    logic signed [I_BW-1:0] data_i;
    logic                   di_en;
    logic signed [I_BW-1:0] data_o;
    logic                   do_en;
    logic [NW-1:0]          out_num;
    logic                   frame_last;
    logic                   done;
    logic                   overrun;

    modport master (
        output data_i, di_en,
        input  data_o, do_en, out_num, frame_last, done, overrun
    );

    modport slave (
        input  data_i, di_en,
        output data_o, do_en, out_num, frame_last, done, overrun
    );
endinterface

// File: rtl/audio_framer.sv
// audio_framer: cuts a mono sample stream into overlapping FRAME_LEN frames spaced HOP_LEN
// apart and bursts each frame out. Define AUDIO_FRAMER_PREEMPH_EN for write-side pre-emphasis.
module audio_framer #(
    parameter int I_BW       = 14,
    parameter int FRAME_LEN  = 1024,
    parameter int HOP_LEN    = 512,
    parameter int TOTAL_DATA = 91136
) (
    input  logic          clk,
    input  logic          rst,
    audio_framer_if.slave bus
);
    localparam int NUM_FRAMES = TOTAL_DATA / FRAME_LEN;
    localparam int CAP_TOTAL  = (NUM_FRAMES - 1) * HOP_LEN + FRAME_LEN;
    localparam int AW         = $clog2(2 * FRAME_LEN);
    localparam int PW         = $clog2(FRAME_LEN);
    localparam int FW         = $clog2(NUM_FRAMES + 1);
    localparam int CW         = $clog2(CAP_TOTAL + 1);
    localparam int NW         = $clog2(TOTAL_DATA);

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    logic signed [I_BW-1:0] ram [2*FRAME_LEN];

    state_t                 state;
    state_t                 nxt_state;
    logic [CW-1:0]          wr_cnt;
    logic signed [I_BW-1:0] wr_data;
    logic                   accept;
    logic                   trig;

    logic                   trig_q;
    logic [AW-1:0]          trig_base;
    logic [AW-1:0]          trig_base_q;
    logic [FW-1:0]          trig_cnt;
    logic [FW-1:0]          trig_frame_q;

    logic                   pend_valid;
    logic [AW-1:0]          pend_base;
    logic [FW-1:0]          pend_frame;

    logic [AW-1:0]          base;
    logic [AW-1:0]          rd_addr;
    logic [PW-1:0]          pos;
    logic [FW-1:0]          frame_idx;

    logic                   rd_en;
    logic                   last_read;
    logic                   load_pend;
    logic                   load_trig;
    logic                   set_pend;
    logic                   drop;

    logic signed [I_BW-1:0] data_o_r;
    logic                   do_en_r;
    logic [NW-1:0]          out_num_r;
    logic                   frame_last_r;
    logic                   done_r;
    logic                   overrun_r;

    // A frame is ready once its last sample lands: index k*HOP_LEN + FRAME_LEN - 1.
    assign accept = bus.di_en && !done_r && (wr_cnt != CW'(CAP_TOTAL));
    assign trig   = accept && (wr_cnt >= CW'(FRAME_LEN - 1))
                 && (((wr_cnt + CW'(1)) & CW'(HOP_LEN - 1)) == '0);

`ifdef AUDIO_FRAMER_PREEMPH_EN
    localparam logic signed [I_BW+1:0] SAT_MAX = (I_BW+2)'((1 << (I_BW - 1)) - 1);
    localparam logic signed [I_BW+1:0] SAT_MIN = -SAT_MAX - (I_BW+2)'(1);

    logic signed [I_BW-1:0] x_prev;
    logic signed [I_BW+1:0] x_ext;
    logic signed [I_BW+1:0] p_ext;
    logic signed [I_BW+1:0] pre_full;

    // y = x[n] - x[n-1] + x[n-1]/32, widened so the sum cannot wrap before clamping.
    always_comb begin
        x_ext    = {{2{bus.data_i[I_BW-1]}}, bus.data_i};
        p_ext    = {{2{x_prev[I_BW-1]}}, x_prev};
        pre_full = x_ext - p_ext + (p_ext >>> 5);
        if (pre_full > SAT_MAX)
            wr_data = SAT_MAX[I_BW-1:0];
        else if (pre_full < SAT_MIN)
            wr_data = SAT_MIN[I_BW-1:0];
        else
            wr_data = pre_full[I_BW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            x_prev <= '0;
        else if (accept)
            x_prev <= bus.data_i;
    end
`else
    assign wr_data = bus.data_i;
`endif

    always_ff @(posedge clk) begin
        if (accept)
            ram[wr_cnt[AW-1:0]] <= wr_data;
    end

    // Triggers are registered one cycle so the FSM sees frame number and start address together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt       <= '0;
            trig_q       <= 1'b0;
            trig_base    <= '0;
            trig_base_q  <= '0;
            trig_cnt     <= '0;
            trig_frame_q <= '0;
        end else begin
            trig_q <= trig;
            if (accept)
                wr_cnt <= wr_cnt + CW'(1);
            if (trig) begin
                trig_base_q  <= trig_base;
                trig_frame_q <= trig_cnt;
                trig_base    <= trig_base + AW'(HOP_LEN);
                trig_cnt     <= trig_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    // The pending slot is judged before the last read frees it, so a trigger that meets a
    // full slot is dropped even on the final read cycle; with an empty slot it runs back-to-back.
    always_comb begin
        nxt_state = state;
        load_pend = 1'b0;
        load_trig = 1'b0;
        set_pend  = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load_pend = 1'b1;
                    set_pend  = trig_q;
                    nxt_state = EMIT;
                end else if (trig_q) begin
                    load_trig = 1'b1;
                    nxt_state = EMIT;
                end
            end
            EMIT: begin
                if (last_read) begin
                    if (pend_valid) begin
                        load_pend = 1'b1;
                        drop      = trig_q;
                    end else if (trig_q)
                        load_trig = 1'b1;
                    else if (trig_cnt == FW'(NUM_FRAMES))
                        nxt_state = FIN;
                    else
                        nxt_state = IDLE;
                end else if (trig_q) begin
                    if (pend_valid)
                        drop = 1'b1;
                    else
                        set_pend = 1'b1;
                end
            end
            FIN:     nxt_state = FIN;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        rd_en     = (state == EMIT);
        last_read = rd_en && (pos == PW'(FRAME_LEN - 1));
        rd_addr   = base + AW'(pos);
    end

    // Read pointer, pending slot and the registered output stage all advance together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base         <= '0;
            pos          <= '0;
            frame_idx    <= '0;
            pend_valid   <= 1'b0;
            pend_base    <= '0;
            pend_frame   <= '0;
            data_o_r     <= '0;
            do_en_r      <= 1'b0;
            out_num_r    <= '0;
            frame_last_r <= 1'b0;
            done_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (load_pend) begin
                base      <= pend_base;
                frame_idx <= pend_frame;
                pos       <= '0;
            end else if (load_trig) begin
                base      <= trig_base_q;
                frame_idx <= trig_frame_q;
                pos       <= '0;
            end else if (rd_en)
                pos <= pos + PW'(1);

            if (set_pend) begin
                pend_valid <= 1'b1;
                pend_base  <= trig_base_q;
                pend_frame <= trig_frame_q;
            end else if (load_pend)
                pend_valid <= 1'b0;

            do_en_r      <= rd_en;
            frame_last_r <= last_read;
            if (rd_en) begin
                data_o_r  <= ram[rd_addr];
                out_num_r <= NW'({frame_idx, pos});
            end

            if (drop)
                overrun_r <= 1'b1;
            if (state == FIN)
                done_r <= 1'b1;
        end
    end

    assign bus.data_o     = data_o_r;
    assign bus.do_en      = do_en_r;
    assign bus.out_num    = out_num_r;
    assign bus.frame_last = frame_last_r;
    assign bus.done       = done_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer on a scaled configuration (16-sample frames, hop 8, 9 frames).
module tb_audio_framer;
    localparam int I_BW  = 14;
    localparam int F     = 16;
    localparam int H     = 8;
    localparam int TOTAL = 144;
    localparam int NW    = $clog2(TOTAL);

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    audio_framer_if #(.I_BW(I_BW), .TOTAL_DATA(TOTAL)) bus ();

    audio_framer #(
        .I_BW(I_BW), .FRAME_LEN(F), .HOP_LEN(H), .TOTAL_DATA(TOTAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion before 500000");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic signed [I_BW-1:0] stream_val(input int n, input int off);
        return I_BW'((n + off) % 8192);
    endfunction

    // Value the framer should hold for input sample n of a stream started right after reset.
    function automatic logic signed [I_BW-1:0] stored(input int n, input int off);
`ifdef AUDIO_FRAMER_PREEMPH_EN
        int y;
        int xp;
        xp = (n == 0) ? 0 : int'(stream_val(n - 1, off));
        y  = int'(stream_val(n, off)) - xp + (xp >>> 5);
        if (y > 8191)  y = 8191;
        if (y < -8192) y = -8192;
        return I_BW'(y);
`else
        return stream_val(n, off);
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.di_en  = 1'b0;
        bus.data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.di_en  = 1'b0;
        bus.data_i = '0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.data_o !== '0)     begin errors++; $display("[TB] FAIL reset_data_o: got %0d expected 0", bus.data_o); end
        checks++; if (bus.do_en !== 1'b0)    begin errors++; $display("[TB] FAIL reset_do_en: got %0b expected 0", bus.do_en); end
        checks++; if (bus.out_num !== '0)    begin errors++; $display("[TB] FAIL reset_out_num: got %0d expected 0", bus.out_num); end
        checks++; if (bus.frame_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_last: got %0b expected 0", bus.frame_last); end
        checks++; if (bus.done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
        checks++; if (bus.overrun !== 1'b0)  begin errors++; $display("[TB] FAIL reset_overrun: got %0b expected 0", bus.overrun); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_latency();
        int run_len;
        int last_pos;
        int last_cnt;
        do_reset();
        for (int n = 0; n < F; n++) begin
            bus.di_en  = 1'b1;
            bus.data_i = stream_val(n, 100);
            @(negedge clk);
        end
        bus.di_en = 1'b0;
        checks++; if (bus.do_en !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge_n: do_en got %0b expected 0", bus.do_en); end
        @(negedge clk);
        checks++; if (bus.do_en !== 1'b0) begin errors++; $display("[TB] FAIL latency_edge_n1: do_en got %0b expected 0", bus.do_en); end
        @(negedge clk);
        checks++; if (bus.do_en !== 1'b1) begin errors++; $display("[TB] FAIL latency_edge_n2: do_en got %0b expected 1", bus.do_en); end
        checks++; if (bus.out_num !== NW'(0)) begin errors++; $display("[TB] FAIL latency_out_num: got %0d expected 0", bus.out_num); end
        checks++; if (bus.data_o !== stored(0, 100)) begin errors++; $display("[TB] FAIL latency_data: got %0d expected %0d", bus.data_o, stored(0, 100)); end
        run_len  = 0;
        last_pos = 0;
        last_cnt = 0;
        for (int i = 0; i < 2 * F; i++) begin
            if (!bus.do_en) break;
            run_len++;
            if (bus.frame_last) begin
                last_pos = run_len;
                last_cnt++;
            end
            @(negedge clk);
        end
        checks++; if (run_len != F)  begin errors++; $display("[TB] FAIL frame_length: got %0d do_en cycles expected %0d", run_len, F); end
        checks++; if (last_pos != F || last_cnt != 1) begin errors++; $display("[TB] FAIL frame_last_pos: got pos %0d count %0d expected pos %0d count 1", last_pos, last_cnt, F); end
    endtask

    task automatic test_ramp();
        int n;
        int exp_num;
        int k;
        int p;
        bit prev_last;
        bit got_done;
        do_reset();
        n = 0;
        exp_num = 0;
        prev_last = 1'b0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 1000 && !got_done; cyc++) begin
            if (prev_last) begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL ramp_done_rise: got %0b expected 1", bus.done); end
                got_done = 1'b1;
            end else if (bus.do_en) begin
                k = exp_num / F;
                p = exp_num % F;
                checks++; if (bus.out_num !== NW'(exp_num)) begin errors++; $display("[TB] FAIL ramp_out_num: got %0d expected %0d", bus.out_num, exp_num); end
                checks++; if (bus.data_o !== stored(k * H + p, 0)) begin errors++; $display("[TB] FAIL ramp_data: frame %0d pos %0d got %0d expected %0d", k, p, bus.data_o, stored(k * H + p, 0)); end
                checks++; if (bus.frame_last !== ((p == F - 1) ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL ramp_frame_last: out_num %0d got %0b", exp_num, bus.frame_last); end
                if (exp_num == TOTAL - 1) begin
                    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL ramp_done_early: got %0b expected 0", bus.done); end
                    prev_last = 1'b1;
                end
                exp_num++;
            end
            if (cyc % 2 == 0) begin
                bus.di_en  = 1'b1;
                bus.data_i = stream_val(n, 0);
                n++;
            end else
                bus.di_en = 1'b0;
            @(negedge clk);
        end
        bus.di_en = 1'b0;
        checks++; if (exp_num != TOTAL) begin errors++; $display("[TB] FAIL ramp_count: got %0d samples expected %0d", exp_num, TOTAL); end
        checks++; if (!got_done) begin errors++; $display("[TB] FAIL ramp_done_timeout: done not seen, expected 1"); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL ramp_overrun: got %0b expected 0", bus.overrun); end
    endtask

    task automatic test_after_done();
        int en_seen;
        int done_low;
        en_seen  = 0;
        done_low = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.di_en  = 1'b1;
            bus.data_i = stream_val(i, 7);
            @(negedge clk);
            if (bus.do_en !== 1'b0) en_seen++;
            if (bus.done !== 1'b1)  done_low++;
        end
        bus.di_en = 1'b0;
        checks++; if (en_seen != 0)  begin errors++; $display("[TB] FAIL after_done_do_en: got %0d active cycles expected 0", en_seen); end
        checks++; if (done_low != 0) begin errors++; $display("[TB] FAIL after_done_done: got %0d low cycles expected 0", done_low); end
    endtask

    task automatic test_overrun();
        int exp_frames [5] = '{0, 1, 3, 5, 7};
        int j;
        int fr;
        int p;
        int in_gap;
        bit got_done;
        do_reset();
        j = 0;
        in_gap = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            if (bus.done === 1'b1) got_done = 1'b1;
            if (bus.do_en) begin
                if (j < 5 * F) begin
                    fr = exp_frames[j / F];
                    p  = j % F;
                    checks++; if (bus.out_num !== NW'(fr * F + p)) begin errors++; $display("[TB] FAIL overrun_out_num: got %0d expected %0d", bus.out_num, fr * F + p); end
                    checks++; if (bus.data_o !== stored(fr * H + p, 0)) begin errors++; $display("[TB] FAIL overrun_data: frame %0d pos %0d got %0d expected %0d", fr, p, bus.data_o, stored(fr * H + p, 0)); end
                end
                if (j == F - 2) begin
                    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_early: got %0b expected 0", bus.overrun); end
                end
                if (j == F - 1) begin
                    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %0b expected 1", bus.overrun); end
                end
                if (bus.out_num >= NW'(2 * F) && bus.out_num < NW'(3 * F)) in_gap++;
                j++;
            end
            bus.di_en  = 1'b1;
            bus.data_i = stream_val(cyc, 0);
            @(negedge clk);
        end
        bus.di_en = 1'b0;
        checks++; if (in_gap != 0)   begin errors++; $display("[TB] FAIL overrun_skip: got %0d outputs in frame 2 range expected 0", in_gap); end
        checks++; if (j != 5 * F)    begin errors++; $display("[TB] FAIL overrun_count: got %0d outputs expected %0d", j, 5 * F); end
        checks++; if (!got_done)     begin errors++; $display("[TB] FAIL overrun_done_timeout: done not seen, expected 1"); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %0b expected 1", bus.overrun); end
    endtask

    task automatic test_reset_mid_frame();
        bit hit;
        bit seen;
        do_reset();
        hit = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (bus.do_en && bus.out_num == NW'(3 * F + 5)) begin
                rst = 1'b0;
                #1;
                checks++; if (bus.do_en !== 1'b0)   begin errors++; $display("[TB] FAIL midreset_do_en: got %0b expected 0", bus.do_en); end
                checks++; if (bus.out_num !== '0)   begin errors++; $display("[TB] FAIL midreset_out_num: got %0d expected 0", bus.out_num); end
                checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset_overrun: got %0b expected 0", bus.overrun); end
                hit = 1'b1;
                break;
            end
            bus.di_en  = 1'b1;
            bus.data_i = stream_val(cyc, 0);
            @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("[TB] FAIL midreset_timeout: frame 3 pos 5 not reached, expected it"); end
        bus.di_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.do_en) begin
                checks++; if (bus.out_num !== NW'(0)) begin errors++; $display("[TB] FAIL midreset_first_num: got %0d expected 0", bus.out_num); end
                checks++; if (bus.data_o !== stored(0, 500)) begin errors++; $display("[TB] FAIL midreset_first_data: got %0d expected %0d", bus.data_o, stored(0, 500)); end
                seen = 1'b1;
                break;
            end
            bus.di_en  = 1'b1;
            bus.data_i = stream_val(n, 500);
            @(negedge clk);
        end
        bus.di_en = 1'b0;
        checks++; if (!seen) begin errors++; $display("[TB] FAIL midreset_restart_timeout: no do_en, expected one"); end
    endtask

`ifdef AUDIO_FRAMER_PREEMPH_EN
    task automatic test_preemph();
        logic signed [I_BW-1:0] ins  [3];
        logic signed [I_BW-1:0] exps [4];
        logic signed [I_BW-1:0] want;
        bit seen;
        ins  = '{14'sd8191, 14'sd8191, 14'h2000};
        exps = '{14'sd8191, 14'sd255, 14'h2000, 14'sd7936};
        do_reset();
        for (int n = 0; n < F; n++) begin
            bus.di_en  = 1'b1;
            bus.data_i = (n < 3) ? ins[n] : '0;
            @(negedge clk);
        end
        bus.di_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.do_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL preemph_timeout: no do_en, expected a frame"); end
        for (int p = 0; p < F; p++) begin
            want = (p < 4) ? exps[p] : '0;
            checks++; if (bus.data_o !== want) begin errors++; $display("[TB] FAIL preemph_value: pos %0d got %0d expected %0d", p, bus.data_o, want); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.di_en  = 1'b0;
        bus.data_i = '0;
        $display("[TB] starting audio_framer bench");
        test_reset();
        test_first_latency();
        test_ramp();
        test_after_done();
        test_overrun();
        test_reset_mid_frame();
`ifdef AUDIO_FRAMER_PREEMPH_EN
        test_preemph();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
